// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encoding, instruction opcodes and the
// fixed Capture-IR pattern used by the TAP controller and its FSM.
package jtag_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'd0,
    RUN_TEST_IDLE    = 4'd1,
    SELECT_DR        = 4'd2,
    CAPTURE_DR       = 4'd3,
    SHIFT_DR         = 4'd4,
    EXIT1_DR         = 4'd5,
    PAUSE_DR         = 4'd6,
    EXIT2_DR         = 4'd7,
    UPDATE_DR        = 4'd8,
    SELECT_IR        = 4'd9,
    CAPTURE_IR       = 4'd10,
    SHIFT_IR         = 4'd11,
    EXIT1_IR         = 4'd12,
    PAUSE_IR         = 4'd13,
    EXIT2_IR         = 4'd14,
    UPDATE_IR        = 4'd15
  } tap_state_t;

  // Which data register sits between tdi and tdo during a DR scan
  typedef enum logic [1:0] {
    SEL_BSR    = 2'd0,
    SEL_ID     = 2'd1,
    SEL_BYPASS = 2'd2
  } dr_sel_t;

  localparam logic [3:0] EXTEST         = 4'b0000;
  localparam logic [3:0] IDCODE         = 4'b0001;
  localparam logic [3:0] SAMPLE_PRELOAD = 4'b0010;
  localparam logic [3:0] BYPASS         = 4'b1111;

  // Low two bits loaded on Capture-IR; upper bits are zero
  localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/tap_fsm.sv
// 16-state IEEE 1149.1 TAP state machine. Advances on the rising TCK edge
// from tms and exposes the state plus one-hot helper flags.
module tap_fsm
  import jtag_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tms,
  output tap_state_t state,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       tlr
);

  tap_state_t state_q, state_d;

  // Next-state decode from tms; IR branch mirrors the DR branch
  always_comb begin
    state_d = state_q;
    case (state_q)
      TEST_LOGIC_RESET: state_d = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_d = tms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_DR:        state_d = tms ? SELECT_IR        : CAPTURE_DR;
      CAPTURE_DR:       state_d = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_d = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_d = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_d = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_d = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_d = tms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_IR:        state_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_d = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_d = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_d = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_d = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_d = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_d = tms ? SELECT_DR        : RUN_TEST_IDLE;
      default:          state_d = TEST_LOGIC_RESET;
    endcase
  end

  // State register; reset forces Test-Logic-Reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= TEST_LOGIC_RESET;
    else     state_q <= state_d;
  end

  assign state      = state_q;
  assign capture_dr = (state_q == CAPTURE_DR);
  assign shift_dr   = (state_q == SHIFT_DR);
  assign update_dr  = (state_q == UPDATE_DR);
  assign capture_ir = (state_q == CAPTURE_IR);
  assign shift_ir   = (state_q == SHIFT_IR);
  assign update_ir  = (state_q == UPDATE_IR);
  assign tlr        = (state_q == TEST_LOGIC_RESET);

endmodule

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller driving a boundary scan register chain.
// Holds the instruction register, decoder, bypass register, optional IDCODE
// register, TDO mux and the gated BSR clock / update strobe.
// Optional feature: define JTAG_IDCODE_EN to include the 32-bit ID register;
// the IR then resets to IDCODE instead of BYPASS.
module tap_controller
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH     = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
  input  logic clk,
  input  logic rst,
  input  logic tms,
  input  logic tdi,
  output logic tdo,
  output logic tdo_en,
  input  logic bsr_tdo,
  output logic bsr_clock_dr,
  output logic bsr_shift_dr,
  output logic bsr_update_dr,
  output logic bsr_mode
);

  if (IR_WIDTH < 2) begin : g_bad_ir_width
    $error("tap_controller: IR_WIDTH must be at least 2");
  end
  if (IDCODE_VALUE[0] != 1'b1) begin : g_bad_idcode
    $error("tap_controller: IDCODE_VALUE bit 0 must be 1");
  end

  localparam logic [IR_WIDTH-1:0] OP_EXTEST  = IR_WIDTH'(EXTEST);
  localparam logic [IR_WIDTH-1:0] OP_SAMPLE  = IR_WIDTH'(SAMPLE_PRELOAD);
  localparam logic [IR_WIDTH-1:0] OP_BYPASS  = '1;
  localparam logic [IR_WIDTH-1:0] OP_CAPTURE = IR_WIDTH'(IR_CAPTURE);
`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_RESET   = OP_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] IR_RESET   = OP_BYPASS;
`endif

  tap_state_t state;
  logic capture_dr, shift_dr, update_dr;
  logic capture_ir, shift_ir, update_ir, tlr;

  tap_fsm u_fsm (
    .clk        (clk),
    .rst        (rst),
    .tms        (tms),
    .state      (state),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .capture_ir (capture_ir),
    .shift_ir   (shift_ir),
    .update_ir  (update_ir),
    .tlr        (tlr)
  );

  // Rising-edge shift stages (data only, always captured before use)
  logic [IR_WIDTH-1:0] ir_sh_q, ir_sh_d;
  logic                bypass_q, bypass_d;
  // Falling-edge control registers
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                tdo_q, tdo_d;
  logic                tdo_en_q, tdo_en_d;
  logic                clk_en_q, clk_en_d;
  logic                upd_q, upd_d;

  dr_sel_t dr_sel;
  logic    bsr_sel;
  logic    dr_lsb;

`ifdef JTAG_IDCODE_EN
  logic [31:0] id_q, id_d;
`endif

  // Instruction decode and selected-DR serial output
  always_comb begin
    dr_sel = SEL_BYPASS;
    if (ir_q == OP_EXTEST || ir_q == OP_SAMPLE) dr_sel = SEL_BSR;
`ifdef JTAG_IDCODE_EN
    else if (ir_q == OP_IDCODE) dr_sel = SEL_ID;
`endif
    bsr_sel = (dr_sel == SEL_BSR);
    dr_lsb  = bypass_q;
    if (dr_sel == SEL_BSR) dr_lsb = bsr_tdo;
`ifdef JTAG_IDCODE_EN
    else if (dr_sel == SEL_ID) dr_lsb = id_q[0];
`endif
  end

  // Capture/shift next values for the IR shift stage and bypass bit
  always_comb begin
    ir_sh_d = ir_sh_q;
    if (capture_ir)    ir_sh_d = OP_CAPTURE;
    else if (shift_ir) ir_sh_d = {tdi, ir_sh_q[IR_WIDTH-1:1]};
    bypass_d = bypass_q;
    if (capture_dr)    bypass_d = 1'b0;
    else if (shift_dr) bypass_d = tdi;
  end

  // Rising-edge capture/shift of IR shift stage and bypass register
  always_ff @(posedge clk) begin
    ir_sh_q  <= ir_sh_d;
    bypass_q <= bypass_d;
  end

`ifdef JTAG_IDCODE_EN
  // ID register loads the device word on Capture-DR and shifts LSB-first
  always_comb begin
    id_d = id_q;
    if (dr_sel == SEL_ID) begin
      if (capture_dr)    id_d = IDCODE_VALUE;
      else if (shift_dr) id_d = {tdi, id_q[31:1]};
    end
  end

  // Rising-edge ID shift register
  always_ff @(posedge clk) begin
    id_q <= id_d;
  end
`endif

  // Falling-edge next values: active IR, TDO, BSR clock enable, update strobe
  always_comb begin
    ir_d = ir_q;
    if (tlr)            ir_d = IR_RESET;
    else if (update_ir) ir_d = ir_sh_q;
    tdo_d = tdo_q;
    if (shift_ir)       tdo_d = ir_sh_q[0];
    else if (shift_dr)  tdo_d = dr_lsb;
    tdo_en_d = (state == SHIFT_IR) || (state == SHIFT_DR);
    // Enable only changes while TCK is low, so clk & en cannot glitch
    clk_en_d = bsr_sel && (capture_dr || shift_dr);
    // UPDATE_DR lasts one TCK period, so this self-clears on the next fall
    upd_d    = bsr_sel && update_dr;
  end

  // Falling-edge control registers; reset aborts any scan in progress
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      ir_q     <= IR_RESET;
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
      clk_en_q <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
      clk_en_q <= clk_en_d;
      upd_q    <= upd_d;
    end
  end

  assign tdo           = tdo_q;
  assign tdo_en        = tdo_en_q;
  assign bsr_clock_dr  = clk & clk_en_q;
  assign bsr_shift_dr  = shift_dr;
  assign bsr_update_dr = upd_q;
  assign bsr_mode      = (state != TEST_LOGIC_RESET) && (ir_q == OP_EXTEST);

endmodule

// File: tb/tb_tap_controller.sv
// Testbench for tap_controller: FSM transition table, directed IR/DR scans
// against an 8-cell boundary scan chain, mid-scan reset, and random tms/tdi
// traffic checked against a transition-table reference model.
module tb_tap_controller;
  import jtag_pkg::*;

  localparam int          IR_W   = 4;
  localparam logic [31:0] IDV    = 32'h1000_0001;
  localparam logic [7:0]  PIN_IN = 8'h3C;
`ifdef JTAG_IDCODE_EN
  localparam logic [IR_W-1:0] IR_RST = 4'b0001;
  localparam bit              HAS_ID = 1'b1;
`else
  localparam logic [IR_W-1:0] IR_RST = 4'b1111;
  localparam bit              HAS_ID = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tms = 1'b1;
  logic tdi = 1'b0;
  logic tdo, tdo_en, bsr_tdo, bsr_clock_dr, bsr_shift_dr, bsr_update_dr, bsr_mode;

  always #5 clk = ~clk;

  tap_controller #(.IR_WIDTH(IR_W), .IDCODE_VALUE(IDV)) dut (
    .clk           (clk),
    .rst           (rst),
    .tms           (tms),
    .tdi           (tdi),
    .tdo           (tdo),
    .tdo_en        (tdo_en),
    .bsr_tdo       (bsr_tdo),
    .bsr_clock_dr  (bsr_clock_dr),
    .bsr_shift_dr  (bsr_shift_dr),
    .bsr_update_dr (bsr_update_dr),
    .bsr_mode      (bsr_mode)
  );

  // 8-cell boundary scan chain driven by the controller
  logic [7:0] bsr_cap = 8'h00;
  logic [7:0] bsr_upd = 8'h00;
  logic [7:0] parallel_out;
  int clk_edges  = 0;
  int upd_pulses = 0;

  always @(posedge bsr_clock_dr) begin
    clk_edges <= clk_edges + 1;
    if (bsr_shift_dr) bsr_cap <= {tdi, bsr_cap[7:1]};
    else              bsr_cap <= PIN_IN;
  end

  always @(posedge bsr_update_dr) begin
    upd_pulses <= upd_pulses + 1;
    bsr_upd    <= bsr_cap;
  end

  assign bsr_tdo      = bsr_cap[0];
  assign parallel_out = bsr_mode ? bsr_upd : PIN_IN;

  // Reference model: states 0..15 as TLR,RTI,SelDR,CapDR,ShDR,Ex1DR,PauDR,
  // Ex2DR,UpdDR,SelIR,CapIR,ShIR,Ex1IR,PauIR,Ex2IR,UpdIR
  int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  int              ms     = 0;
  logic [IR_W-1:0] m_ir   = '0;
  logic [IR_W-1:0] m_irsh = '0;
  logic            m_byp  = 1'b0;
  logic [31:0]     m_id   = '0;
  logic [7:0]      m_bsr  = '0;
  logic            m_tdo  = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic       t;
    tap_state_t st;
  } fsm_vec_t;
  fsm_vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // 0 = boundary scan, 1 = ID register, 2 = bypass
  function automatic int m_sel();
    if (m_ir == 4'b0000 || m_ir == 4'b0010) return 0;
    if (HAS_ID && m_ir == 4'b0001) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    ms    = 0;
    m_ir  = IR_RST;
    m_tdo = 1'b0;
  endtask

  // One TCK cycle: drive inputs while clk is low, advance model, compare
  task automatic tick(input logic t, input logic d);
    int sel;
    tms = t;
    tdi = d;
    @(posedge clk);
    sel = m_sel();
    case (ms)
      3: begin
        m_byp = 1'b0;
        if (sel == 1) m_id = IDV;
        if (sel == 0) m_bsr = PIN_IN;
      end
      4: begin
        m_byp = d;
        if (sel == 1) m_id = {d, m_id[31:1]};
        if (sel == 0) m_bsr = {d, m_bsr[7:1]};
      end
      10: m_irsh = IR_W'(1);
      11: m_irsh = {d, m_irsh[IR_W-1:1]};
      default: ;
    endcase
    ms = t ? nxt1[ms] : nxt0[ms];
    @(negedge clk);
    #1;
    sel = m_sel();
    if (ms == 4)       m_tdo = (sel == 0) ? m_bsr[0] : (sel == 1) ? m_id[0] : m_byp;
    else if (ms == 11) m_tdo = m_irsh[0];
    check("tdo_en", tdo_en, (ms == 4) || (ms == 11));
    check("tdo", tdo, m_tdo);
    check("update_dr", bsr_update_dr, (ms == 8) && (sel == 0));
    check("shift_dr", bsr_shift_dr, ms == 4);
    if (ms == 0)       m_ir = IR_RST;
    else if (ms == 15) m_ir = m_irsh;
    check("mode", bsr_mode, (ms != 0) && (m_ir == 4'b0000));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_state", dut.state, TEST_LOGIC_RESET);
    check("rst_tdo", tdo, 1'b0);
    check("rst_tdo_en", tdo_en, 1'b0);
    check("rst_update", bsr_update_dr, 1'b0);
    check("rst_mode", bsr_mode, 1'b0);
    check("rst_clock_dr", bsr_clock_dr, 1'b0);
    check("rst_ir", dut.ir_q, IR_RST);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Starting in Run-Test/Idle; returns the bits seen on tdo, LSB first
  task automatic load_ir(input logic [IR_W-1:0] val, output logic [IR_W-1:0] cap);
    cap = '0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < IR_W; i++) begin
      cap[i] = tdo;
      tick(i == IR_W - 1, val[i]);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
    dout = '0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo;
      tick(i == n - 1, din[i]);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic add_vec(input logic t, input tap_state_t s);
    fsm_vec_t v;
    v.t  = t;
    v.st = s;
    vecs.push_back(v);
  endtask

  initial begin
    logic [IR_W-1:0] irc;
    logic [31:0]     d;
    int e0, u0;

    add_vec(0, RUN_TEST_IDLE);  add_vec(1, SELECT_DR);   add_vec(0, CAPTURE_DR);
    add_vec(0, SHIFT_DR);       add_vec(1, EXIT1_DR);    add_vec(0, PAUSE_DR);
    add_vec(1, EXIT2_DR);       add_vec(0, SHIFT_DR);    add_vec(1, EXIT1_DR);
    add_vec(1, UPDATE_DR);      add_vec(1, SELECT_DR);   add_vec(1, SELECT_IR);
    add_vec(0, CAPTURE_IR);     add_vec(1, EXIT1_IR);    add_vec(0, PAUSE_IR);
    add_vec(1, EXIT2_IR);       add_vec(1, UPDATE_IR);   add_vec(1, SELECT_DR);
    add_vec(1, SELECT_IR);      add_vec(1, TEST_LOGIC_RESET);
    add_vec(0, RUN_TEST_IDLE);  add_vec(1, SELECT_DR);   add_vec(0, CAPTURE_DR);
    add_vec(0, SHIFT_DR);       add_vec(1, EXIT1_DR);    add_vec(1, UPDATE_DR);
    add_vec(1, SELECT_DR);      add_vec(1, SELECT_IR);   add_vec(1, TEST_LOGIC_RESET);
    add_vec(0, RUN_TEST_IDLE);  add_vec(1, SELECT_DR);   add_vec(1, SELECT_IR);
    add_vec(0, CAPTURE_IR);     add_vec(0, SHIFT_IR);    add_vec(1, EXIT1_IR);
    add_vec(0, PAUSE_IR);       add_vec(1, EXIT2_IR);    add_vec(0, SHIFT_IR);
    add_vec(1, EXIT1_IR);       add_vec(1, UPDATE_IR);   add_vec(0, RUN_TEST_IDLE);
    add_vec(1, SELECT_DR);      add_vec(1, SELECT_IR);   add_vec(1, TEST_LOGIC_RESET);

    #12;
    do_reset();

    // TAP transition table
    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].t, 1'b0);
      check($sformatf("fsm_step%0d", i), dut.state, vecs[i].st);
    end

    // DR scan straight after Test-Logic-Reset
    tick(1'b0, 1'b0);
    check("tlr_ir", dut.ir_q, IR_RST);
    scan_dr(32, 32'h0, d);
    check("idcode_stream", d, HAS_ID ? IDV : 32'h0);

    // IR capture pattern shifted out LSB-first
    load_ir(4'b0010, irc);
    load_ir(4'b1111, irc);
    check("ir_capture", irc, 4'b0001);
    check("ir_bypass", dut.ir_q, 4'b1111);

    // Bypass: one-cycle delay, no BSR clocks
    e0 = clk_edges;
    u0 = upd_pulses;
    scan_dr(4, 32'b1101, d);
    check("bypass_tdo", d[3:0], 4'b1010);
    check("bypass_clk_edges", clk_edges - e0, 0);
    check("bypass_updates", upd_pulses - u0, 0);

    // SAMPLE_PRELOAD then EXTEST through the 8-cell chain
    load_ir(4'b0010, irc);
    check("sample_mode", bsr_mode, 1'b0);
    e0 = clk_edges;
    u0 = upd_pulses;
    scan_dr(8, 32'hA5, d);
    check("sample_capture", d[7:0], PIN_IN);
    check("sample_clk_edges", clk_edges - e0, 9);
    check("sample_updates", upd_pulses - u0, 1);
    check("sample_update_stage", bsr_upd, 8'hA5);
    check("sample_pins", parallel_out, PIN_IN);
    load_ir(4'b0000, irc);
    check("extest_mode", bsr_mode, 1'b1);
    check("extest_pins", parallel_out, 8'hA5);
    check("extest_updates", upd_pulses - u0, 1);

    // Reset in the middle of a BSR Shift-DR with the gated clock high
    load_ir(4'b0010, irc);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    u0 = upd_pulses;
    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    check("abort_updates", upd_pulses - u0, 0);

    // Random traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      tick($urandom_range(0, 3) == 0, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tap_controller.md
Name: tap_controller

Overview:
- IEEE 1149.1 TAP controller that sequences the boundary scan register chain and selects between it, a bypass register and an optional IDCODE register.
- Contains the 16-state TAP FSM, instruction register, instruction decoder and TDO mux.
- Drives the chain's capture/shift clock, shift select, update strobe and mode.
- Sits between the chip JTAG pins and the BSR chain.

Parameters:
- IR_WIDTH, 4, instruction register width; minimum 2.
- IDCODE_VALUE, 32'h1000_0001, device ID word; bit 0 must be 1.

Ports:
- clk  input  1  TCK; FSM advances on rising edge, TDO and updates act on falling edge.
- rst  input  1  asynchronous, active-high reset; forces Test-Logic-Reset.
- tms  input  1  test mode select.
- tdi  input  1  test data in; also wired directly to the BSR chain input.
- tdo  output  1  test data out, registered on falling edge.
- tdo_en  output  1  high while in Shift-IR or Shift-DR, registered on falling edge.
- bsr_tdo  input  1  serial output of the last BSR cell.
- bsr_clock_dr  output  1  gated TCK for the BSR capture/shift flops.
- bsr_shift_dr  output  1  BSR shift (1) / capture (0) select.
- bsr_update_dr  output  1  BSR update strobe; the rising edge latches the update stage.
- bsr_mode  output  1  BSR output mux select (1 = drive from the update stage).

Behaviour:
- Reset values:
  - state = TEST_LOGIC_RESET.
  - IR = IDCODE when JTAG_IDCODE_EN is defined, else BYPASS.
  - tdo = 0, tdo_en = 0, bsr_update_dr = 0, bsr_mode = 0, bsr_clock_dr = 0.
  - Reset mid-scan aborts immediately; no BSR update occurs.
- FSM: standard 16 states, transitions on posedge clk from tms:
  - TLR: tms=0 -> RTI.
  - RTI: tms=1 -> SEL_DR.
  - SEL_DR: tms=1 -> SEL_IR, tms=0 -> CAP_DR.
  - CAP_DR / SHIFT_DR: tms=1 -> EXIT1_DR.
  - EXIT1_DR: tms=1 -> UPD_DR, else PAUSE_DR.
  - PAUSE_DR: tms=1 -> EXIT2_DR.
  - EXIT2_DR: tms=1 -> UPD_DR, else SHIFT_DR.
  - UPD_DR: tms=1 -> SEL_DR, else RTI.
  - IR branch mirrors the DR branch; SEL_IR with tms=1 -> TLR.
  - Five consecutive tms=1 reach TLR from any state.
- IR path:
  - Capture-IR loads the shift stage with {0..., 2'b01}.
  - Shift-IR shifts LSB-first from tdi.
  - Update-IR copies the shift stage to the active IR on the falling edge.
  - Entering TLR resets the active IR to its reset value.
- Decode (active IR):
  - 0000 EXTEST: BSR selected, mode=1.
  - 0010 SAMPLE_PRELOAD: BSR selected, mode=0.
  - 0001 IDCODE: 32-bit ID register.
  - 1111 BYPASS, and every other code: 1-bit bypass register.
- bsr_mode: follows decode combinationally from the active IR; 0 in TLR.
- Bypass register: cleared on Capture-DR, loaded with tdi on each Shift-DR rising edge.
- bsr_shift_dr: 1 iff state == SHIFT_DR.
- bsr_clock_dr:
  - Equals clk AND en.
  - en is registered on the falling edge: high when BSR is selected and state ∈ {CAP_DR, SHIFT_DR}.
  - Glitch-free because en changes only while clk is low.
  - Pause/Exit states give no BSR edges.
- bsr_update_dr:
  - Set on the falling edge in UPD_DR when BSR is selected; cleared on the next falling edge.
  - Exactly one pulse per Update-DR.
  - Never asserted for bypass, IDCODE or IR scans.
- TDO:
  - On each falling edge in SHIFT_IR, tdo = IR shift LSB.
  - In SHIFT_DR, tdo = LSB of the selected DR (bypass bit, ID shift LSB, or bsr_tdo).
  - Otherwise tdo holds its value and tdo_en = 0.
- Capture-DR with IDCODE loads IDCODE_VALUE into the 32-bit ID shift register.

Optional Feature:
- JTAG_IDCODE_EN defined:
  - ID register present; opcode 0001 decodes to IDCODE.
  - IR resets to IDCODE, so a DR scan straight after reset returns IDCODE_VALUE.
- Not defined:
  - No ID register; 0001 decodes as BYPASS.
  - IR resets to BYPASS.

Decomposition:
- Package jtag_pkg holds:
  - tap_state_t enum (16 states, 4-bit encoding).
  - Opcode constants EXTEST, IDCODE, SAMPLE_PRELOAD, BYPASS.
  - IR capture pattern constant.
- Sub-module tap_fsm: clk, rst, tms -> state plus one-hot helper flags (capture/shift/update for IR and DR, tlr).
- tap_controller holds IR, decoder, bypass/ID registers and TDO/clock gating.

Test Plan:
- Reset: assert rst mid Shift-DR -> state TLR, tdo_en=0, bsr_update_dr=0, active IR=0001 (macro on) or 1111 (off).
- TLR from any state: from PAUSE_IR drive tms=1 x5 -> TLR; any 4 ones from SHIFT_DR -> not yet TLR.
- IR capture: load IR=0010, then scan IR with tdi=1 -> first 4 tdo bits LSB-first 1,0,0,0; active IR becomes 1111.
- IDCODE (macro on): after reset, go to SHIFT_DR and shift 32 -> tdo stream LSB-first equals 32'h1000_0001.
- Bypass: IR=1111, shift DR with tdi pattern 1,0,1,1 -> tdo 0,1,0,1 (one-cycle delay), bsr_clock_dr never pulses.
- EXTEST: with an 8-cell BSR, SAMPLE_PRELOAD shifting 8'hA5, then IR=EXTEST.
  - Expect bsr_update_dr pulsed exactly once (Update-DR), bsr_mode=1.
  - Expect parallel_out=8'hA5; exactly 9 bsr_clock_dr rising edges (1 capture + 8 shift) during the DR scan.
